// File: rtl/dds_pkg.sv
// Purpose: shared constants and helpers for the quadrature DDS (quadrant codes,
//          quarter-wave fold, table entry generator).
// Latency: n/a (package). Backpressure: n/a.
// Table hex files generated by the table script follow the name pattern
// quarter_sin_<ADDR_WIDTH>_<OUT_WIDTH>.hex; contents equal quarter_sin_mag().
package dds_pkg;

  // Quadrant encoding taken from the top two phase bits.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Widest quarter-wave address the fold helper handles; callers zero-extend
  // their address in and truncate the result back to their own width.
  localparam int FOLD_AW = 16;

  localparam real HALF_PI = 1.5707963267948966;

  // Odd quadrants walk the quarter table backwards; bitwise inversion is an
  // exact mirror because entries sit at half-sample positions.
  function automatic logic [FOLD_AW-1:0] fold_addr(input logic [1:0] quad,
                                                   input logic [FOLD_AW-1:0] addr);
    logic [FOLD_AW-1:0] r;
    r = addr;
    case (quad)
      Q1, Q3:  r = ~addr;
      default: r = addr;
    endcase
    return r;
  endfunction

  // Lower half of the circle is the negated upper half.
  function automatic logic fold_neg(input logic [1:0] quad);
    logic n;
    n = 1'b0;
    case (quad)
      Q2, Q3:  n = 1'b1;
      default: n = 1'b0;
    endcase
    return n;
  endfunction

  // Table entry i = round((2^(out_w-1)-1) * sin(pi/2 * (i+0.5) / 2^addr_w)).
  function automatic int quarter_sin_mag(input int idx, input int addr_w, input int out_w);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = HALF_PI * (real'(idx) + 0.5) / real'(1 << addr_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_quadrature_core_rom.sv
// Purpose: dual-read-port quarter-wave sine ROM, 2^ADDR_WIDTH x (OUT_WIDTH-1).
// Latency: 1 cycle, registered read; outputs update only when rd_en_i=1.
// Backpressure: none; read data holds while rd_en_i=0.
// Ports: clk, rst_n, rd_en_i, addr_a_i/addr_b_i (read addresses),
//        dat_a_o/dat_b_o (unsigned magnitudes).
module quarter_sin_rom
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [OUT_WIDTH-2:0]  dat_a_o,
  output logic [OUT_WIDTH-2:0]  dat_b_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MAG_W = OUT_WIDTH - 1;

  logic [MAG_W-1:0] rom [DEPTH];
  logic [MAG_W-1:0] dat_a_q, dat_b_q;

  // Constant table, elaborated from the same formula the hex generator uses.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = MAG_W'(quarter_sin_mag(i, ADDR_WIDTH, OUT_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_a_q <= '0;
      dat_b_q <= '0;
    end else if (rd_en_i) begin
      dat_a_q <= rom[addr_a_i];
      dat_b_q <= rom[addr_b_i];
    end
  end

  assign dat_a_o = dat_a_q;
  assign dat_b_o = dat_b_q;

endmodule

// File: rtl/dds_quadrature_core.sv
// Purpose: quadrature DDS: phase accumulator + folded quarter-wave ROM -> signed sin/cos.
// Latency: 3 edges from en sampled high to out_valid; one sample per cycle.
// Backpressure: none; en gaps propagate as out_valid gaps, outputs hold between samples.
// Ports: clk, rst_n, en, ftw_in/ftw_load (tuning word), sync_clr (phase reset),
//        poff_in (phase offset), out_valid, sin_out, cos_out.
module dds_quadrature_core
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [PHASE_WIDTH-1:0]      ftw_in,
  input  logic                        ftw_load,
  input  logic                        sync_clr,
  input  logic [PHASE_WIDTH-1:0]      poff_in,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] sin_out,
  output logic signed [OUT_WIDTH-1:0] cos_out
);

  localparam int MAG_W  = OUT_WIDTH - 1;
  localparam int FULL_W = ADDR_WIDTH + 2;
  localparam int SHIFT  = PHASE_WIDTH - FULL_W;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d, ftw_q, ftw_d;
  logic [FULL_W-1:0]      phase_top;
  logic [1:0]             sin_quad, cos_quad;
  logic [ADDR_WIDTH-1:0]  fine_addr;
  logic [ADDR_WIDTH-1:0]  s_addr_d, c_addr_d, s_addr_q, c_addr_q;
  logic                   s_neg1_q, c_neg1_q, s_neg2_q, c_neg2_q;
  logic                   v1_q, v2_q, out_valid_q;
  logic [MAG_W-1:0]       s_mag, c_mag;
  logic [OUT_WIDTH-1:0]   s_ext, c_ext, sin_d, cos_d, sin_q, cos_q;

  always_comb begin
    acc_d = acc_q;
    if (sync_clr)  acc_d = '0;
    else if (en)   acc_d = acc_q + ftw_q;
    ftw_d = ftw_load ? ftw_in : ftw_q;
  end

  // Stage 1 lookup uses the pre-update accumulator; only the top FULL_W
  // phase bits matter, so the sum is shifted down before it is kept.
  always_comb begin
    phase_top = FULL_W'((acc_q + poff_in) >> SHIFT);
    sin_quad  = phase_top[FULL_W-1 -: 2];
    fine_addr = phase_top[ADDR_WIDTH-1:0];
    cos_quad  = sin_quad + 2'd1;  // cosine leads sine by one quadrant
    s_addr_d  = ADDR_WIDTH'(fold_addr(sin_quad, FOLD_AW'(fine_addr)));
    c_addr_d  = ADDR_WIDTH'(fold_addr(cos_quad, FOLD_AW'(fine_addr)));
  end

  quarter_sin_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (v1_q),
    .addr_a_i (s_addr_q),
    .addr_b_i (c_addr_q),
    .dat_a_o  (s_mag),
    .dat_b_o  (c_mag)
  );

  // Peak magnitude is 2^(OUT_WIDTH-1)-1, so negation cannot overflow.
  always_comb begin
    s_ext = OUT_WIDTH'(s_mag);
    c_ext = OUT_WIDTH'(c_mag);
    sin_d = s_neg2_q ? -s_ext : s_ext;
    cos_d = c_neg2_q ? -c_ext : c_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ftw_q       <= '0;
      v1_q        <= 1'b0;
      s_addr_q    <= '0;
      c_addr_q    <= '0;
      s_neg1_q    <= 1'b0;
      c_neg1_q    <= 1'b0;
      v2_q        <= 1'b0;
      s_neg2_q    <= 1'b0;
      c_neg2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
      v1_q  <= en;
      if (en) begin
        s_addr_q <= s_addr_d;
        c_addr_q <= c_addr_d;
        s_neg1_q <= fold_neg(sin_quad);
        c_neg1_q <= fold_neg(cos_quad);
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s_neg2_q <= s_neg1_q;
        c_neg2_q <= c_neg1_q;
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;

endmodule

// File: tb/tb_dds_quadrature_core.sv
// Purpose: directed self-checking bench for dds_quadrature_core (default widths).
// Latency: n/a. Backpressure: n/a.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_dds_quadrature_core;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [31:0]       ftw_in = '0;
  logic              ftw_load = 1'b0;
  logic              sync_clr = 1'b0;
  logic [31:0]       poff_in = '0;
  logic              out_valid;
  logic signed [7:0] sin_out, cos_out;

  int n_checks = 0;
  int n_fail   = 0;
  int s_max, s_min;

  dds_quadrature_core #(
    .PHASE_WIDTH (32),
    .ADDR_WIDTH  (8),
    .OUT_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ftw_in    (ftw_in),
    .ftw_load  (ftw_load),
    .sync_clr  (sync_clr),
    .poff_in   (poff_in),
    .out_valid (out_valid),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal full-wave sample at 10-bit phase index k (half-sample centred),
  // rounded half away from zero.
  function automatic int model_wave(input int k, input bit is_cos);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / 1024.0;
    v   = 127.0 * (is_cos ? $cos(ang) : $sin(ang));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Load ftw together with sync_clr, then check nsamp consecutive samples
  // starting at phase poff and stepping by ftw.
  task automatic run_sweep(input logic [31:0] ftw, input int nsamp, input string tag);
    int k0, stride, k, s, c, pwr;
    ftw_in = ftw; ftw_load = 1'b1; sync_clr = 1'b1; en = 1'b1;
    step();
    ftw_load = 1'b0; sync_clr = 1'b0;
    step();
    step();
    k0 = int'(poff_in[31:22]);
    stride = int'(ftw[31:22]);
    for (int n = 0; n < nsamp; n++) begin
      step();
      k = (k0 + n * stride) % 1024;
      s = int'(sin_out);
      c = int'(cos_out);
      check({tag, "_vld"}, int'(out_valid), 1);
      check({tag, "_sin"}, s, model_wave(k, 1'b0));
      check({tag, "_cos"}, c, model_wave(k, 1'b1));
      pwr = s * s + c * c - 16129;
      check({tag, "_pwr"}, int'(pwr <= 322 && pwr >= -322), 1);
      if (s > s_max) s_max = s;
      if (s < s_min) s_min = s;
    end
  endtask

  initial begin
    bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int k_at [7];
    int k_next, last_k;
    bit have;

    // Reset state
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_vld", int'(out_valid), 0);
    check("rst_sin", int'(sin_out), 0);
    check("rst_cos", int'(cos_out), 0);
    rst_n = 1'b1;

    // 1: ftw=0, poff=0 -> constant (0, +127) after 3 edges
    en = 1'b1;
    step(); check("t1_vld_e1", int'(out_valid), 0);
    step(); check("t1_vld_e2", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_vld", int'(out_valid), 1);
      check("t1_sin", int'(sin_out), 0);
      check("t1_cos", int'(cos_out), 127);
    end

    // 2: quadrant offsets
    poff_in = 32'h4000_0000; step(); step(); step();
    check("t2_90_sin", int'(sin_out), 127);
    check("t2_90_cos", int'(cos_out), 0);
    poff_in = 32'h8000_0000; step(); step(); step();
    check("t2_180_sin", int'(sin_out), 0);
    check("t2_180_cos", int'(cos_out), -127);
    poff_in = 32'hC000_0000; step(); step(); step();
    check("t2_270_sin", int'(sin_out), -127);
    check("t2_270_cos", int'(cos_out), 0);

    // 3: full sweep, index step 4, one period plus a few samples
    poff_in = '0;
    s_max = -1000; s_min = 1000;
    run_sweep(32'h0100_0000, 260, "t3");
    check("t3_max", s_max, 127);
    check("t3_min", s_min, -127);

    // 4: en gaps propagate, outputs hold, accumulator only moves on en
    en = 1'b0;
    step(); step(); step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    k_next = 0; last_k = 0; have = 1'b0;
    for (int j = 0; j < 10; j++) begin
      en = (j < 7) ? pat[j] : 1'b0;
      step();
      if (j < 7 && pat[j]) begin
        k_at[j] = k_next;
        k_next += 4;
      end
      if (j >= 2 && j - 2 < 7) begin
        check("t4_vld", int'(out_valid), int'(pat[j-2]));
        if (pat[j-2]) begin
          last_k = k_at[j-2];
          have = 1'b1;
        end
      end else begin
        check("t4_vld_idle", int'(out_valid), 0);
      end
      if (have) begin
        check("t4_sin", int'(sin_out), model_wave(last_k, 1'b0));
        check("t4_cos", int'(cos_out), model_wave(last_k, 1'b1));
      end
    end

    // 5: ftw_load + sync_clr together mid-run, with a 90-degree offset
    poff_in = 32'h4000_0000;
    en = 1'b1;
    repeat (5) step();
    run_sweep(32'h0200_0000, 8, "t5");

    // 6: async reset with samples in flight
    step(); step();
    rst_n = 1'b0;
    #2;
    check("t6_rst_vld", int'(out_valid), 0);
    check("t6_rst_sin", int'(sin_out), 0);
    check("t6_rst_cos", int'(cos_out), 0);
    step();
    check("t6_hold_vld", int'(out_valid), 0);
    rst_n = 1'b1;
    step(); check("t6_vld_e1", int'(out_valid), 0);
    step(); check("t6_vld_e2", int'(out_valid), 0);
    step();
    check("t6_vld_e3", int'(out_valid), 1);
    check("t6_sin", int'(sin_out), 127);
    check("t6_cos", int'(cos_out), 0);
    step();
    check("t6_sin_next", int'(sin_out), 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_quadrature_core.md
# dds_quadrature_core

Parametrised quadrature DDS core. A phase accumulator drives a quarter-wave sine ROM that folds across all four quadrants, producing signed sine and cosine samples. Width, table depth and phase resolution are all parameters. It sits between the softDDS control registers (tuning word, phase offset) and the DAC/output formatting stage, and replaces the fixed 8x8 full-amplitude table with a pipelined, signed, two-output generator.

## Interface
- PHASE_WIDTH, 32, accumulator, tuning word and phase offset width
- ADDR_WIDTH, 8, quarter-wave table address bits (full-wave resolution ADDR_WIDTH+2)
- OUT_WIDTH, 8, signed output width including sign; table magnitude is OUT_WIDTH-1 bits
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance accumulator and launch one sample per cycle
- ftw_in  in  PHASE_WIDTH  frequency tuning word
- ftw_load  in  1  capture ftw_in on this edge
- sync_clr  in  1  clear phase accumulator on this edge
- poff_in  in  PHASE_WIDTH  phase offset, added combinationally at the lookup; no latch
- out_valid  out  1  sin_out/cos_out carry a new sample
- sin_out  out  OUT_WIDTH  signed sine sample
- cos_out  out  OUT_WIDTH  signed cosine sample

## Operation
- Reset clears all registers: acc=0, ftw=0, stage valids=0, out_valid=0, sin_out=0, cos_out=0.
- FTW register loads ftw_in when ftw_load=1, regardless of en. The new value is used from the next edge onward.
- Accumulator update, in priority order:
  - sync_clr=1: acc<=0, even if en=1.
  - en=1: acc<=acc+ftw, modulo 2^PHASE_WIDTH, wrap silent.
  - otherwise: hold.
- If ftw_load and sync_clr are asserted together, both take effect.
- Stage 1 (when en=1): p = acc+poff_in (modulo 2^PHASE_WIDTH), using the pre-update acc.
  - q = p[top 2 bits]; a = next ADDR_WIDTH bits.
  - Sine path: q0 → addr a, positive; q1 → ~a, positive; q2 → a, negative; q3 → ~a, negative.
  - Cosine path: same rule applied to (q+1) mod 4.
  - Register both addresses and both sign bits; v1<=en.
- Stage 2: synchronous read of both ROM ports; v2<=v1.
- Stage 3: out = sign ? -mag : mag, with mag zero-extended to OUT_WIDTH; out_valid<=v2.
- Data registers in each stage load only when that stage's incoming valid is 1. sin_out/cos_out therefore hold the last sample while out_valid=0.
- ROM entry i = round((2^(OUT_WIDTH-1)-1)·sin(π/2·(i+0.5)/2^ADDR_WIDTH)).
  - The half-sample offset makes ~a fold exactly and avoids duplicated peaks/zeros.
  - Maximum magnitude is 2^(OUT_WIDTH-1)-1, so negation never overflows.

## Timing
- Latency is 3 edges: en=1 sampled at edge k gives out_valid=1 after edge k+2, carrying phase acc(k)+poff_in(k).
- Throughput: one sample per cycle while en=1. out_valid follows en delayed by 3 edges, with gaps preserved.
- sync_clr at edge k: the sample launched at edge k+1 uses phase 0+poff.
- Samples already in flight complete normally after en drops.
- rst_n low mid-operation drops everything immediately and asynchronously; no in-flight sample emerges. After release, the first out_valid comes 3 edges after en is first sampled high.
- No combinational path from any input to any output.

## Structure
- Package dds_pkg holds:
  - quadrant encoding constants Q0..Q3;
  - a fold function (quadrant, addr) → (rom_addr, negate);
  - the ROM file-name convention quarter_sin_<ADDR_WIDTH>_<OUT_WIDTH>.hex, generated by the existing table script.
- Sub-module quarter_sin_rom: dual-read-port synchronous ROM, 2^ADDR_WIDTH × (OUT_WIDTH-1), initialised from the hex file. It is the only memory in the block.

## Test plan
1. Reset, ftw=0, poff=0, en=1 → after 3 edges out_valid=1, sin_out=0, cos_out=+127, steady every cycle.
2. poff=0x4000_0000 → sin_out=+127, cos_out=0. poff=0x8000_0000 → sin_out=0, cos_out=-127. poff=0xC000_0000 → sin_out=-127, cos_out=0.
3. ftw=0x0100_0000 → table index steps by 4 per sample. Waveform repeats every 256 samples; sin crosses zero rising at samples 0 and 256; min/max exactly ±127; sin²+cos² within 2% of 127².
4. Toggle en in pattern 1,1,0,1,0,0,1 → out_valid reproduces the same pattern 3 edges later. Outputs hold during zeros, and accumulator advances only on en=1.
5. Assert ftw_load with ftw_in=0x0200_0000 and sync_clr on the same edge mid-run → third sample after that edge shows phase 0. Index then steps by 8 per sample.
6. Assert rst_n low asynchronously between edges with samples in flight → all outputs and out_valid go 0 immediately. After release with en=1, the first valid sample arrives exactly 3 edges later with phase poff.
